pipelined_shifter: RTL and testbench

Parametrised, pipelined barrel shifter for the ALU datapath. It extends the combinational SLL-only shifter to logical-left, logical-right and arithmetic-right shifts at configurable width. One register stage follows each log2 shift level, so the ALU clock is not limited by a full-width mux chain. A valid/ready handshake with backpressure connects it to the ALU result mux.

---
 rtl/pipelined_shifter.sv | 144 ++++++++++++++
 tb/tb_pipelined_shifter.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_shifter.sv
// Pipelined barrel shifter (SLL/SRL/SRA) with one register stage per log2 shift level
// and a global-stall valid/ready handshake; the last stage register drives the outputs.
module pipelined_shifter #(
    parameter int WIDTH  = 32,
    parameter int LEVELS = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inValid,
    output logic             inReady,
    input  logic [WIDTH-1:0] dataA,
    input  logic [WIDTH-1:0] dataB,
    input  logic [5:0]       Signal,
    output logic             outValid,
    input  logic             outReady,
    output logic [WIDTH-1:0] dataOut
);

    typedef enum logic [1:0] {
        MODE_SLL = 2'd0,
        MODE_SRL = 2'd1,
        MODE_SRA = 2'd2,
        MODE_INV = 2'd3
    } mode_t;

    logic advance;

    // Request decode
    mode_t             in_mode;
    logic              in_fill;
    logic              in_ovf;
    logic [LEVELS-1:0] in_amt;

    always_comb begin
        in_mode = MODE_INV;
        case (Signal)
            6'b000000: in_mode = MODE_SLL;
            6'b000010: in_mode = MODE_SRL;
            6'b000011: in_mode = MODE_SRA;
            default:   in_mode = MODE_INV;
        endcase
        in_fill = (in_mode == MODE_SRA) && dataA[WIDTH-1];
        in_ovf  = |dataB[WIDTH-1:LEVELS];
        in_amt  = dataB[LEVELS-1:0];
    end

    // Per-stage registers; the last stage only needs valid and data
    logic              valid_reg [LEVELS];
    logic [WIDTH-1:0]  data_reg  [LEVELS];
    mode_t             mode_reg  [LEVELS-1];
    logic              fill_reg  [LEVELS-1];
    logic              ovf_reg   [LEVELS-1];
    logic [LEVELS-1:0] amt_reg   [LEVELS-1];

    // Stage inputs
    logic              src_valid [LEVELS];
    logic [WIDTH-1:0]  src_data  [LEVELS];
    mode_t             src_mode  [LEVELS];
    logic              src_fill  [LEVELS];
    logic              src_ovf   [LEVELS];
    logic [LEVELS-1:0] src_amt   [LEVELS];
    logic [WIDTH-1:0]  shifted   [LEVELS];

    assign outValid = valid_reg[LEVELS-1];
    assign dataOut  = data_reg[LEVELS-1];
    assign advance  = !outValid || outReady;
    assign inReady  = advance;

    generate
        for (genvar gi = 0; gi < LEVELS; gi++) begin : g_stage
            localparam int SH = 1 << gi;

            if (gi == 0) begin : g_src_in
                assign src_valid[gi] = inValid;
                assign src_data[gi]  = dataA;
                assign src_mode[gi]  = in_mode;
                assign src_fill[gi]  = in_fill;
                assign src_ovf[gi]   = in_ovf;
                assign src_amt[gi]   = in_amt;
            end else begin : g_src_reg
                assign src_valid[gi] = valid_reg[gi-1];
                assign src_data[gi]  = data_reg[gi-1];
                assign src_mode[gi]  = mode_reg[gi-1];
                assign src_fill[gi]  = fill_reg[gi-1];
                assign src_ovf[gi]   = ovf_reg[gi-1];
                assign src_amt[gi]   = amt_reg[gi-1];
            end

            // Amount is shifted down one bit per stage, so bit 0 always selects this level
            always_comb begin
                shifted[gi] = src_data[gi];
                if (src_amt[gi][0]) begin
                    if (src_mode[gi] == MODE_SLL)
                        shifted[gi] = {src_data[gi][WIDTH-1-SH:0], {SH{1'b0}}};
                    else
                        shifted[gi] = {{SH{src_fill[gi]}}, src_data[gi][WIDTH-1:SH]};
                end
            end

            if (gi < LEVELS - 1) begin : g_mid
                always_ff @(posedge clk) begin
                    if (reset) begin
                        valid_reg[gi] <= 1'b0;
                        data_reg[gi]  <= '0;
                        mode_reg[gi]  <= MODE_SLL;
                        fill_reg[gi]  <= 1'b0;
                        ovf_reg[gi]   <= 1'b0;
                        amt_reg[gi]   <= '0;
                    end else if (advance) begin
                        valid_reg[gi] <= src_valid[gi];
                        data_reg[gi]  <= shifted[gi];
                        mode_reg[gi]  <= src_mode[gi];
                        fill_reg[gi]  <= src_fill[gi];
                        ovf_reg[gi]   <= src_ovf[gi];
                        amt_reg[gi]   <= {1'b0, src_amt[gi][LEVELS-1:1]};
                    end
                end
            end else begin : g_last
                logic [WIDTH-1:0] final_data;

                always_comb begin
                    final_data = shifted[gi];
                    if (src_mode[gi] == MODE_INV)
                        final_data = '0;
                    else if (src_ovf[gi])
                        final_data = (src_mode[gi] == MODE_SRA) ? {WIDTH{src_fill[gi]}} : '0;
                end

                // Bubbles advance the valid bit but never overwrite the held result
                always_ff @(posedge clk) begin
                    if (reset) begin
                        valid_reg[gi] <= 1'b0;
                        data_reg[gi]  <= '0;
                    end else if (advance) begin
                        valid_reg[gi] <= src_valid[gi];
                        if (src_valid[gi])
                            data_reg[gi] <= final_data;
                    end
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_pipelined_shifter.sv
// Scoreboard bench for pipelined_shifter: directed requests push expected results,
// an independent monitor pops and compares whenever a result is consumed.
module tb_pipelined_shifter;

    localparam logic [5:0] SLL = 6'b000000;
    localparam logic [5:0] SRL = 6'b000010;
    localparam logic [5:0] SRA = 6'b000011;
    localparam int LAT = 5;

    logic        clk = 1'b0;
    logic        reset;
    logic        inValid, inReady, outValid, outReady;
    logic [31:0] dataA, dataB, dataOut;
    logic [5:0]  Signal;

    logic       in8_valid, in8_ready, out8_valid, out8_ready;
    logic [7:0] data8_a, data8_b, data8_out;
    logic [5:0] signal8;

    always #5 clk = ~clk;

    pipelined_shifter #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset), .inValid(inValid), .inReady(inReady),
        .dataA(dataA), .dataB(dataB), .Signal(Signal),
        .outValid(outValid), .outReady(outReady), .dataOut(dataOut)
    );

    pipelined_shifter #(.WIDTH(8)) dut8 (
        .clk(clk), .reset(reset), .inValid(in8_valid), .inReady(in8_ready),
        .dataA(data8_a), .dataB(data8_b), .Signal(signal8),
        .outValid(out8_valid), .outReady(out8_ready), .dataOut(data8_out)
    );

    typedef struct {
        logic [31:0] d;
        int          acc;
        bit          lat;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    bit   lat_check = 1'b1;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h", name, got, want);
        end else begin
            $display("ok   %s value=%h", name, got);
        end
    endtask

    // Monitor: a result is consumed at the edge after a negedge showing outValid && outReady
    always @(negedge clk) begin
        if (!reset && outValid && outReady) begin
            if (q.size() == 0) begin
                check("unexpected_result", dataOut, 32'hxxxx_xxxx);
            end else begin
                exp_t e;
                e = q.pop_front();
                check("result", dataOut, e.d);
                if (e.lat) check("latency", 32'(cyc - e.acc), 32'(LAT));
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 after acceptance
    task automatic send(input logic [31:0] a, input logic [31:0] b,
                        input logic [5:0] s, input logic [31:0] e);
        int w;
        exp_t x;
        w = 0;
        inValid = 1'b1; dataA = a; dataB = b; Signal = s;
        @(negedge clk);
        while (!inReady && w < 200) begin
            @(negedge clk);
            w++;
        end
        if (!inReady) begin
            check("send_timeout", 32'(inReady), 32'd1);
        end else begin
            x.d = e; x.acc = cyc; x.lat = lat_check;
            q.push_back(x);
        end
        @(posedge clk);
        #1;
        inValid = 1'b0;
    endtask

    task automatic drain();
        int w;
        w = 0;
        while (q.size() != 0 && w < 100) begin
            @(negedge clk);
            w++;
        end
        check("drain_left", 32'(q.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; inValid = 1'b0; outReady = 1'b1;
        dataA = '0; dataB = '0; Signal = '0;
        in8_valid = 1'b0; out8_ready = 1'b1; data8_a = '0; data8_b = '0; signal8 = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        @(negedge clk);
        check("rst_outValid", 32'(outValid), 32'd0);
        check("rst_dataOut", dataOut, 32'h0);
        check("rst_inReady", 32'(inReady), 32'd1);
        @(posedge clk); #1;

        // Single SLL, latency checked by monitor
        send(32'h0000_0001, 32'd31, SLL, 32'h8000_0000);
        drain();

        // Back-to-back SRA/SRL and boundary amounts
        send(32'h8000_0000, 32'd4, SRA, 32'hF800_0000);
        send(32'h8000_0000, 32'd4, SRL, 32'h0800_0000);
        send(32'h8000_0001, 32'd40, SRA, 32'hFFFF_FFFF);
        send(32'hFFFF_FFFF, 32'd32, SRL, 32'h0);
        send(32'h0000_0001, 32'h0001_0000, SLL, 32'h0);
        send(32'h8765_4321, 32'd0, SRA, 32'h8765_4321);
        send(32'h8000_0000, 32'd31, SRL, 32'h0000_0001);
        send(32'h4000_0000, 32'd36, SRA, 32'h0);
        send(32'hFFFF_FFFF, 32'd1, 6'b100000, 32'h0);
        drain();

        // Backpressure: 8 SLL requests, output stalled 3 cycles after first result
        lat_check = 1'b0;
        outReady = 1'b0;
        fork
            begin
                for (int i = 0; i < 8; i++)
                    send(32'h1, 32'(i), SLL, 32'h1 << i);
            end
            begin
                int w;
                w = 0;
                @(negedge clk);
                while (!outValid && w < 50) begin
                    @(negedge clk);
                    w++;
                end
                check("bp_outValid_rise", 32'(outValid), 32'd1);
                for (int k = 0; k < 3; k++) begin
                    check("bp_inReady_hold", 32'(inReady), 32'd0);
                    check("bp_dataOut_hold", dataOut, 32'h1);
                    @(negedge clk);
                end
                @(posedge clk);
                #1 outReady = 1'b1;
            end
        join
        drain();
        lat_check = 1'b1;

        // Reset mid-flight discards in-flight requests
        send(32'h1, 32'd1, SLL, 32'h2);
        send(32'h1, 32'd2, SLL, 32'h4);
        send(32'h1, 32'd3, SLL, 32'h8);
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        q.delete();
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            check("rstmid_outValid", 32'(outValid), 32'd0);
            check("rstmid_dataOut", dataOut, 32'h0);
        end
        @(posedge clk); #1;
        send(32'h0000_00F0, 32'd4, SRL, 32'h0000_000F);
        drain();

        // WIDTH=8 instance: SLL by 7, 3-cycle latency
        begin
            int acc, w;
            in8_valid = 1'b1; data8_a = 8'h01; data8_b = 8'd7; signal8 = SLL;
            @(negedge clk);
            check("w8_inReady", 32'(in8_ready), 32'd1);
            acc = cyc;
            @(posedge clk);
            #1 in8_valid = 1'b0;
            w = 0;
            @(negedge clk);
            while (!out8_valid && w < 20) begin
                @(negedge clk);
                w++;
            end
            check("w8_outValid", 32'(out8_valid), 32'd1);
            check("w8_latency", 32'(cyc - acc), 32'd3);
            check("w8_dataOut", 32'(data8_out), 32'h80);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
